key_event_arb: RTL

KEY_EVENT_ARB -- requirements
Module: key_event_arb

---
 rtl/key_event_arb.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/key_event_arb.sv
// key_event_arb -- debounced key scanner with a round-robin event arbiter.
//
// Each raw key is synchronized (2 flops), then debounced on a slow sample
// tick (one tick every SR+1 clocks): DEB consecutive differing samples flip
// the debounced level. A debounced press raises a pending event for that
// key. Pending events are offered one at a time on a valid/ready port,
// granted round-robin starting after the last delivered key.
//
// Optional feature (macro KEY_EVENT_ARB_AUTOREPEAT_EN): while a key stays
// debounced-pressed, a held counter generates a long event after LONG ticks
// and repeat events every REP ticks after that. Without the macro, only
// short press events exist and ev_long is tied low.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   key       raw asynchronous key levels, 1 = pressed
//   ev_valid  event offered
//   ev_ready  consumer accepts the offered event
//   ev_code   index of the key that produced the event
//   ev_long   1 = long/repeat event, 0 = short press
//   ovf       sticky: an event was dropped because one was already pending
module key_event_arb #(
  parameter int SR    = 999,
  parameter int NKEYS = 4,
  parameter int DEB   = 3,
  parameter int LONG  = 500,
  parameter int REP   = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NKEYS-1:0]         key,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(NKEYS)-1:0] ev_code,
  output logic                     ev_long,
  output logic                     ovf
);

  localparam int TW = (SR > 0) ? $clog2(SR + 1) : 1;
  localparam int RW = $clog2(DEB + 1);
  localparam int CW = $clog2(NKEYS);

  if (NKEYS < 2 || NKEYS > 16 || DEB < 1 || DEB > 8 || LONG < 1 || REP < 1) begin : g_cfg_check
    $error("key_event_arb: parameter out of range");
  end

  typedef enum logic {IDLE, OFFER} state_t;

  logic [NKEYS-1:0] sync1, sync2;
  logic [TW-1:0]    tcnt;
  logic             tick;
  logic [NKEYS-1:0] deb, deb_nxt, rise;
  logic [RW-1:0]    run     [NKEYS];
  logic [RW-1:0]    run_nxt [NKEYS];
  logic [NKEYS-1:0] pend, set_ev, clr;
  logic [CW-1:0]    rr, gidx;
  logic             grant, found, hs;
  state_t           state, state_nxt;

  // Synchronizer and sample tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      tcnt  <= TW'(SR);
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      tcnt  <= (tcnt == '0) ? TW'(SR) : tcnt - 1'b1;
    end
  end

  assign tick = (tcnt == '0);

  // Debounce: a run of DEB differing samples flips the level
  always_comb begin
    deb_nxt = deb;
    for (int k = 0; k < NKEYS; k++) begin
      run_nxt[k] = run[k];
      if (tick) begin
        if (sync2[k] != deb[k]) begin
          if (run[k] == RW'(DEB - 1)) begin
            deb_nxt[k] = ~deb[k];
            run_nxt[k] = '0;
          end else begin
            run_nxt[k] = run[k] + 1'b1;
          end
        end else begin
          run_nxt[k] = '0;
        end
      end
    end
  end

  assign rise = deb_nxt & ~deb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb <= '0;
      for (int k = 0; k < NKEYS; k++) run[k] <= '0;
    end else begin
      deb <= deb_nxt;
      for (int k = 0; k < NKEYS; k++) run[k] <= run_nxt[k];
    end
  end

`ifdef KEY_EVENT_ARB_AUTOREPEAT_EN
  localparam int HMAX = (LONG > REP) ? LONG : REP;
  localparam int HW   = $clog2(HMAX + 1);

  // rpt[k] = 0: counting toward the first long event (LONG ticks);
  // rpt[k] = 1: counting toward the next repeat (REP ticks). The counter
  // restarts from 0 at each event, so it never exceeds its target.
  logic [HW-1:0]    held     [NKEYS];
  logic [HW-1:0]    held_nxt [NKEYS];
  logic [NKEYS-1:0] rpt, rpt_nxt, fall, set_lng, lng;

  assign fall = deb & ~deb_nxt;

  always_comb begin
    rpt_nxt = rpt;
    set_lng = '0;
    for (int k = 0; k < NKEYS; k++) begin
      held_nxt[k] = held[k];
      if (fall[k]) begin
        held_nxt[k] = '0;
        rpt_nxt[k]  = 1'b0;
      end else if (tick && deb[k]) begin
        if (int'(held[k]) + 1 == (rpt[k] ? REP : LONG)) begin
          held_nxt[k] = '0;
          rpt_nxt[k]  = 1'b1;
          set_lng[k]  = 1'b1;
        end else begin
          held_nxt[k] = held[k] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt <= '0;
      for (int k = 0; k < NKEYS; k++) held[k] <= '0;
    end else begin
      rpt <= rpt_nxt;
      for (int k = 0; k < NKEYS; k++) held[k] <= held_nxt[k];
    end
  end

  assign set_ev = rise | set_lng;
`else
  assign set_ev  = rise;
  assign ev_long = 1'b0;
`endif

  // Arbiter: round-robin search from rr over pending keys
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    gidx      = '0;
    grant     = 1'b0;
    state_nxt = state;
    for (int i = 0; i < NKEYS; i++) begin
      idx = (int'(rr) + i) % NKEYS;
      if (!found && pend[idx]) begin
        found = 1'b1;
        gidx  = CW'(idx);
      end
    end
    case (state)
      IDLE:    if (found) begin
                 grant     = 1'b1;
                 state_nxt = OFFER;
               end
      OFFER:   if (ev_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    for (int k = 0; k < NKEYS; k++) clr[k] = grant && (gidx == CW'(k));
  end

  assign ev_valid = (state == OFFER);
  assign hs       = ev_valid && ev_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pending flags, offered event and round-robin pointer.
  // A new event on a key whose flag is being granted this cycle is kept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= '0;
      ovf     <= 1'b0;
      ev_code <= '0;
      rr      <= '0;
`ifdef KEY_EVENT_ARB_AUTOREPEAT_EN
      lng     <= '0;
      ev_long <= 1'b0;
`endif
    end else begin
      if (grant) begin
        ev_code <= gidx;
`ifdef KEY_EVENT_ARB_AUTOREPEAT_EN
        ev_long <= lng[gidx];
`endif
      end
      if (hs) rr <= (ev_code == CW'(NKEYS - 1)) ? '0 : ev_code + 1'b1;
      for (int k = 0; k < NKEYS; k++) begin
        if (set_ev[k]) begin
          if (pend[k] && !clr[k]) begin
            ovf <= 1'b1;
          end else begin
            pend[k] <= 1'b1;
`ifdef KEY_EVENT_ARB_AUTOREPEAT_EN
            lng[k]  <= set_lng[k];
`endif
          end
        end else if (clr[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

endmodule
